// File: rtl/slow_mem_pkg.sv
// Shared types and constants for the slow line-memory responder.
// One responder serves one cache port (I-side or D-side).
package slow_mem_pkg;

  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // True when no line-address bit at or above idx_w is set.
  function automatic logic addr_in_range(input logic [MEM_ADDR_W-1:0] addr,
                                         input int                    idx_w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MEM_ADDR_W; i++) begin
      if ((i >= idx_w) && addr[i]) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/slow_mem_array.sv
// Single-port synchronous line RAM with a write-first registered read port.
// The output register is cleared whenever no read is requested.
module slow_mem_array
  import slow_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  // Read register: write-first so a write response returns the new line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {LINE_W{1'b0}};
    end else if (re) begin
      rdata_q <= we ? wdata : mem_q[idx];
    end else begin
      rdata_q <= {LINE_W{1'b0}};
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/slow_mem_responder.sv
// Fixed-latency responder for the 128-bit cache line interface, with sticky
// flags for cache-side protocol violations.
module slow_mem_responder
  import slow_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 8,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  err_conflict,
  output logic                  err_unstable,
  output logic                  err_range
);

  localparam logic [CNT_W-1:0] LAT_M1_C = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  op_e                     op_q;
  logic                    rd_q, wr_q, ok_q;
  logic [MEM_ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]       wdata_q;
  logic                    mem_ready_q;
  logic                    err_conflict_q, err_unstable_q, err_range_q;

  logic                    req_s, accept_s, enter_resp_s;
  op_e                     live_op_s, cur_op_s;
  logic                    live_ok_s, cur_ok_s;
  logic [ADDR_W-1:0]       cur_idx_s;
  logic [LINE_W-1:0]       cur_wdata_s;
  logic                    ram_we_s, ram_re_s, unstable_s;

  assign req_s     = mem_read | mem_write;
  assign live_op_s = mem_write ? OP_WR : OP_RD;
  assign live_ok_s = addr_in_range(mem_addr, ADDR_W);

  // Next-state and counter logic; LATENCY=1 skips BUSY entirely.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          accept_s = 1'b1;
          if (LATENCY <= 1) begin
            state_d      = RESP;
            cnt_d        = ZERO_C;
            enter_resp_s = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1_C;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q <= ONE_C) begin
          state_d      = RESP;
          cnt_d        = ZERO_C;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = ZERO_C;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO_C;
      end
    endcase
  end

  // Transaction view at RESP entry: live inputs when coming straight from IDLE.
  always_comb begin
    cur_op_s    = op_q;
    cur_ok_s    = ok_q;
    cur_idx_s   = addr_q[ADDR_W-1:0];
    cur_wdata_s = wdata_q;
    if (state_q == IDLE) begin
      cur_op_s    = live_op_s;
      cur_ok_s    = live_ok_s;
      cur_idx_s   = mem_addr[ADDR_W-1:0];
      cur_wdata_s = mem_wdata;
    end else begin
      cur_op_s    = op_q;
      cur_ok_s    = ok_q;
      cur_idx_s   = addr_q[ADDR_W-1:0];
      cur_wdata_s = wdata_q;
    end
  end

  assign ram_we_s = enter_resp_s & (cur_op_s == OP_WR) & cur_ok_s & ~proc_reset;
  assign ram_re_s = enter_resp_s & cur_ok_s & ~proc_reset;

  // wdata only matters for writes, so reads may let it float.
  assign unstable_s = (state_q == BUSY) &&
                      ((mem_read != rd_q) || (mem_write != wr_q) ||
                       (mem_addr != addr_q) ||
                       ((op_q == OP_WR) && (mem_wdata != wdata_q)));

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
      cnt_q   <= ZERO_C;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch captured on acceptance; a conflicting request becomes a write.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      op_q    <= OP_RD;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ok_q    <= 1'b0;
      addr_q  <= {MEM_ADDR_W{1'b0}};
      wdata_q <= {LINE_W{1'b0}};
    end else if (accept_s) begin
      op_q    <= live_op_s;
      rd_q    <= mem_read;
      wr_q    <= mem_write;
      ok_q    <= live_ok_s;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end else begin
      op_q    <= op_q;
      rd_q    <= rd_q;
      wr_q    <= wr_q;
      ok_q    <= ok_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
    end
  end

  // Completion pulse and sticky error flags.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      mem_ready_q    <= 1'b0;
      err_conflict_q <= 1'b0;
      err_unstable_q <= 1'b0;
      err_range_q    <= 1'b0;
    end else begin
      mem_ready_q    <= enter_resp_s;
      err_conflict_q <= err_conflict_q | (mem_read & mem_write);
      err_unstable_q <= err_unstable_q | unstable_s;
      err_range_q    <= err_range_q | (accept_s & ~live_ok_s);
    end
  end

  slow_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .rst  (proc_reset),
    .we   (ram_we_s),
    .re   (ram_re_s),
    .idx  (cur_idx_s),
    .wdata(cur_wdata_s),
    .rdata(mem_rdata)
  );

  assign mem_ready    = mem_ready_q;
  assign err_conflict = err_conflict_q;
  assign err_unstable = err_unstable_q;
  assign err_range    = err_range_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed bench: one responder at LATENCY=8 and one at LATENCY=1.
module tb_slow_mem_responder;

  logic         clk;
  logic         proc_reset;
  logic         rd8, wr8, rd1, wr1;
  logic [27:0]  addr8, addr1;
  logic [127:0] wd8, wd1;
  logic [127:0] rdata8, rdata1;
  logic         ready8, ready1;
  logic         ec8, eu8, er8, ec1, eu1, er1;

  int checks = 0;
  int passed = 0;

  localparam logic [127:0] D_A  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D_AA = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam logic [127:0] D_3  = 128'h33333333000000001111111122222222;
  localparam logic [127:0] D_4  = 128'h44444444FFFFFFFF5555555566666666;
  localparam logic [127:0] D_7  = 128'h77777777777777770000000000000007;
  localparam logic [127:0] D_9  = 128'h99999999999999990000000000000009;
  localparam logic [127:0] D_0  = 128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00;
  localparam logic [127:0] D_X  = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [127:0] D_2  = 128'h22222222222222222222222222222222;
  localparam logic [127:0] D_N  = 128'hBADBADBADBADBADBADBADBADBADBAD00;

  slow_mem_responder #(.ADDR_W(10), .LATENCY(8), .CNT_W(8)) dut8 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd8), .mem_write(wr8),
    .mem_addr(addr8), .mem_wdata(wd8), .mem_rdata(rdata8), .mem_ready(ready8),
    .err_conflict(ec8), .err_unstable(eu8), .err_range(er8)
  );

  slow_mem_responder #(.ADDR_W(10), .LATENCY(1), .CNT_W(8)) dut1 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(addr1), .mem_wdata(wd1), .mem_rdata(rdata1), .mem_ready(ready1),
    .err_conflict(ec1), .err_unstable(eu1), .err_range(er1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [27:0] addr, input logic [127:0] wd);
    if (sel == 0) begin
      rd8 = rd; wr8 = wr; addr8 = addr; wd8 = wd;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wd;
    end
  endtask

  // Counts cycles from the request cycle (k0) until mem_ready; -1 if it never comes.
  task automatic wait_ready(input int sel, input int k0, output int lat,
                            output logic [127:0] data);
    bit done;
    done = 1'b0;
    lat  = -1;
    data = 128'd0;
    for (int k = k0; k < k0 + 300 && !done; k++) begin
      @(negedge clk);
      if ((sel == 0) ? ready8 : ready1) begin
        lat  = k;
        data = (sel == 0) ? rdata8 : rdata1;
        done = 1'b1;
      end
    end
  endtask

  task automatic do_txn(input int sel, input logic rd, input logic wr,
                        input logic [27:0] addr, input logic [127:0] wd,
                        output int lat, output logic [127:0] data);
    @(posedge clk); #1;
    drive(sel, rd, wr, addr, wd);
    wait_ready(sel, 0, lat, data);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, addr, wd);
  endtask

  task automatic test_reset;
    proc_reset = 1'b1;
    drive(0, 1'b0, 1'b0, 28'd0, 128'd0);
    drive(1, 1'b0, 1'b0, 28'd0, 128'd0);
    repeat (3) @(posedge clk);
    #1 proc_reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready8, ec8, eu8, er8} !== 4'b0000) $display("FAIL reset_flags8: got %b expected 0000", {ready8, ec8, eu8, er8});
    else passed++;
    checks++;
    if (rdata8 !== 128'd0) $display("FAIL reset_rdata8: got %h expected 0", rdata8);
    else passed++;
    checks++;
    if ({ready1, ec1, eu1, er1} !== 4'b0000) $display("FAIL reset_flags1: got %b expected 0000", {ready1, ec1, eu1, er1});
    else passed++;
    checks++;
    if (rdata1 !== 128'd0) $display("FAIL reset_rdata1: got %h expected 0", rdata1);
    else passed++;
  endtask

  task automatic test_write_read;
    int lat;
    logic [127:0] d;
    do_txn(0, 1'b0, 1'b1, 28'h0000010, D_A, lat, d);
    checks++;
    if (lat !== 8) $display("FAIL wr_latency: got %0d expected 8", lat);
    else passed++;
    checks++;
    if (d !== D_A) $display("FAIL wr_resp_data: got %h expected %h", d, D_A);
    else passed++;
    @(negedge clk);
    checks++;
    if (ready8 !== 1'b0 || rdata8 !== 128'd0) $display("FAIL ready_single_pulse: got %b/%h expected 0/0", ready8, rdata8);
    else passed++;
    do_txn(0, 1'b1, 1'b0, 28'h0000010, 128'd0, lat, d);
    checks++;
    if (lat !== 8) $display("FAIL rd_latency: got %0d expected 8", lat);
    else passed++;
    checks++;
    if (d !== D_A) $display("FAIL rd_data: got %h expected %h", d, D_A);
    else passed++;
    checks++;
    if ({ec8, eu8, er8} !== 3'b000) $display("FAIL clean_errs: got %b expected 000", {ec8, eu8, er8});
    else passed++;
  endtask

  task automatic test_latency1;
    int lat;
    logic [127:0] d;
    do_txn(1, 1'b0, 1'b1, 28'd3, D_3, lat, d);
    checks++;
    if (lat !== 1) $display("FAIL l1_wr_latency: got %0d expected 1", lat);
    else passed++;
    do_txn(1, 1'b0, 1'b1, 28'd4, D_4, lat, d);
    do_txn(1, 1'b1, 1'b0, 28'd3, 128'd0, lat, d);
    checks++;
    if (lat !== 1 || d !== D_3) $display("FAIL l1_read: got %0d/%h expected 1/%h", lat, d, D_3);
    else passed++;
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 28'd3, 128'd0);
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b0) $display("FAIL b2b_t0: got %b expected 0", ready1);
    else passed++;
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b1 || rdata1 !== D_3) $display("FAIL b2b_first: got %b/%h expected 1/%h", ready1, rdata1, D_3);
    else passed++;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 28'd4, 128'd0);
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b0 || rdata1 !== 128'd0) $display("FAIL b2b_t2: got %b/%h expected 0/0", ready1, rdata1);
    else passed++;
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b1 || rdata1 !== D_4) $display("FAIL b2b_second: got %b/%h expected 1/%h", ready1, rdata1, D_4);
    else passed++;
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 28'd0, 128'd0);
  endtask

  task automatic test_conflict;
    int lat;
    logic [127:0] d;
    do_txn(0, 1'b1, 1'b1, 28'd5, D_AA, lat, d);
    checks++;
    if (lat !== 8 || d !== D_AA) $display("FAIL conflict_resp: got %0d/%h expected 8/%h", lat, d, D_AA);
    else passed++;
    checks++;
    if ({ec8, eu8, er8} !== 3'b100) $display("FAIL conflict_flags: got %b expected 100", {ec8, eu8, er8});
    else passed++;
    do_txn(0, 1'b1, 1'b0, 28'd5, 128'd0, lat, d);
    checks++;
    if (d !== D_AA) $display("FAIL conflict_stored: got %h expected %h", d, D_AA);
    else passed++;
  endtask

  task automatic test_unstable;
    int lat;
    logic [127:0] d;
    do_txn(0, 1'b0, 1'b1, 28'd7, D_7, lat, d);
    do_txn(0, 1'b0, 1'b1, 28'd9, D_9, lat, d);
    checks++;
    if (eu8 !== 1'b0) $display("FAIL unstable_pre: got %b expected 0", eu8);
    else passed++;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 28'd7, 128'd0);
    repeat (3) @(posedge clk);
    #1 addr8 = 28'd9;
    wait_ready(0, 3, lat, d);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 28'd0, 128'd0);
    checks++;
    if (lat !== 8 || d !== D_7) $display("FAIL unstable_resp: got %0d/%h expected 8/%h", lat, d, D_7);
    else passed++;
    checks++;
    if (eu8 !== 1'b1) $display("FAIL unstable_flag: got %b expected 1", eu8);
    else passed++;
  endtask

  task automatic test_range;
    int lat;
    logic [127:0] d;
    do_txn(0, 1'b0, 1'b1, 28'd0, D_0, lat, d);
    checks++;
    if (er8 !== 1'b0) $display("FAIL range_pre: got %b expected 0", er8);
    else passed++;
    do_txn(0, 1'b0, 1'b1, 28'h4000000, D_X, lat, d);
    checks++;
    if (lat !== 8 || d !== 128'd0) $display("FAIL range_wr_resp: got %0d/%h expected 8/0", lat, d);
    else passed++;
    checks++;
    if (er8 !== 1'b1) $display("FAIL range_flag: got %b expected 1", er8);
    else passed++;
    do_txn(0, 1'b1, 1'b0, 28'h4000000, 128'd0, lat, d);
    checks++;
    if (lat !== 8 || d !== 128'd0) $display("FAIL range_rd_resp: got %0d/%h expected 8/0", lat, d);
    else passed++;
    do_txn(0, 1'b1, 1'b0, 28'd0, 128'd0, lat, d);
    checks++;
    if (d !== D_0) $display("FAIL range_idx0_kept: got %h expected %h", d, D_0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [127:0] d;
    bit seen;
    do_txn(0, 1'b0, 1'b1, 28'd2, D_2, lat, d);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 28'd2, D_N);
    repeat (4) @(posedge clk);
    #1;
    proc_reset = 1'b1;
    drive(0, 1'b0, 1'b0, 28'd0, 128'd0);
    @(negedge clk);
    seen = ready8;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready8, ec8, eu8, er8} !== 4'b0000) $display("FAIL midrst_flags: got %b expected 0000", {ready8, ec8, eu8, er8});
    else passed++;
    checks++;
    if (rdata8 !== 128'd0) $display("FAIL midrst_rdata: got %h expected 0", rdata8);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | ready8;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL midrst_no_ready: got %b expected 0", seen);
    else passed++;
    do_txn(0, 1'b1, 1'b0, 28'd2, 128'd0, lat, d);
    checks++;
    if (lat !== 8 || d !== D_2) $display("FAIL midrst_storage: got %0d/%h expected 8/%h", lat, d, D_2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency1();
    test_back_to_back();
    test_conflict();
    test_unstable();
    test_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
